pes_freqdiv_ctrl: RTL and testbench
===================================

# pes_freqdiv_ctrl

Ratio controller for the 4-bit programmable clock divider. It accepts divide-ratio change requests from up to NREQ requesters and grants them round-robin. For each granted request it sequences the divider through a disable/load/re-enable cycle so the ratio changes only while the divider counters are held in reset. After a fixed lock interval it acknowledges the requester. It sits between the clock-management requesters and the divider's `en`/`n` inputs.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `SETTLE`, 2: cycles `div_en` is held low before the new ratio is loaded, ≥1.
- `LOCK`, 16: cycles after re-enable before the request is acknowledged, ≥1.
- `DEF_N`, 2: divide ratio driven after reset, 2..15.

- `clkin`  in  1  controller and divider reference clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  level request per requester; held until its `done` bit is seen.
- `req_n`  in  4*NREQ  requested ratio, slice i = `req_n[4*i+3:4*i]`; stable while `req[i]`=1.
- `done`  out  NREQ  one-hot, one-cycle acknowledge to the served requester.
- `err`  out  1  high together with `done` when the served ratio was rejected.
- `busy`  out  1  high in every state except IDLE.
- `div_en`  out  1  enable to the divider.
- `div_n`  out  4  ratio to the divider.

## Operation
- All outputs are registered. Reset values: `div_en`=0, `div_n`=DEF_N, `done`=0, `err`=0, `busy`=0, state IDLE, round-robin pointer 0.
- `rst` asserted in any state returns to reset values on that edge. An in-flight requester gets no `done` and must keep or re-raise `req`.
- States:
  - IDLE: `div_en`=1.
  - DRAIN: `div_en`=0, for SETTLE cycles.
  - LOAD: `div_en`=0, 1 cycle.
  - LOCK: `div_en`=1, for LOCK cycles.
  - DONE: 1 cycle.
- IDLE, `req`≠0: select the winner as the first set bit at or after the pointer, wrapping at NREQ. Latch the winner index and its `req_n` slice. Set the pointer to winner+1 mod NREQ.
  - Latched ratio <2 (0 or 1): go to DONE with `err`=1. `div_en` and `div_n` are untouched.
  - Otherwise: go to DRAIN with `div_en`<=0.
- DRAIN: a down-counter loaded with SETTLE-1 counts to 0, then moves to LOAD.
- LOAD: `div_n`<=latched ratio; go to LOCK with `div_en`<=1.
- LOCK: a counter of width clog2(LOCK+1) counts LOCK cycles, then moves to DONE.
- DONE: `done[winner]`=1 and `err` as latched for exactly one cycle; next edge returns to IDLE.
- `div_n` changes only on the LOAD edge and only while `div_en`=0.
- Requests arriving outside IDLE wait. `req` changes outside IDLE are ignored; the latched values are used.
- Simultaneous requests: exactly one is served per pass. A requester cannot be served twice in a row while others are pending.

## Timing
- `req` sampled high in IDLE at edge E0:
  - `busy`=1 and `div_en`=0 from E0.
  - `div_n` takes the new value at edge E0+SETTLE+1, when `div_en` also returns to 1.
  - `done` is high in the cycle after edge E0+SETTLE+1+LOCK.
  - Total request-to-done latency is SETTLE+LOCK+2 cycles.
- Rejected ratio: `done`/`err` are high in the cycle after E0 (latency 1), and `div_en` never drops.
- After DONE, IDLE lasts at least one cycle before the next grant edge. The served requester must drop `req` by the edge that ends its `done` cycle.
- First edge after `rst` falls: `div_en` becomes 1 with `div_n`=DEF_N.

## Configuration
- `FREQDIV_CTRL_SKIP_EN` defined: a valid latched ratio equal to the current `div_n` goes straight from IDLE to DONE with latency 1. `div_en` stays 1 and `err`=0.
- Not defined: equal ratios run the full DRAIN/LOAD/LOCK sequence like any other valid ratio.

## Test plan
- Reset, then idle 5 cycles -> `div_en`=1, `div_n`=2, `done`=0, `busy`=0.
- `req[1]`=1 with `req_n`=5 (SETTLE=2, LOCK=16) -> `div_en` low for exactly 3 cycles, `div_n`=5 at the re-enable edge, `done`=4'b0010 exactly 20 cycles after the sample edge, `err`=0.
- `req`=4'b1111 with distinct valid ratios, each requester dropping `req` on its `done` -> grants in order 0,1,2,3. Then `req`=4'b0101 -> grants in order 0,2.
- `req[3]`=1 with `req_n`=0, then with `req_n`=1 -> `done[3]`=1 and `err`=1 one cycle after sampling; `div_en` stays 1; `div_n` is unchanged.
- `rst` pulsed during LOCK -> next cycle `div_n`=DEF_N, `div_en`=0, `busy`=0, no `done`. The held request is re-served from IDLE.
- Request for the current ratio -> with `FREQDIV_CTRL_SKIP_EN`, `done` at latency 1 and no `div_en` drop; without it, full latency SETTLE+LOCK+2.

Source files
------------

// File: rtl/pes_freqdiv_ctrl.sv
// Ratio controller for the 4-bit programmable clock divider; optional feature macro: FREQDIV_CTRL_SKIP_EN.
// Latency: request to done is SETTLE+LOCK+2 cycles, or 1 cycle for rejected (and, with the macro, unchanged) ratios.
// Backpressure: requests are level-held; one round-robin grant per pass, and requests are only sampled in IDLE.
module pes_freqdiv_ctrl #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 2,
  parameter int LOCK   = 16,
  parameter int DEF_N  = 2
) (
  input  logic              i_clkin,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [4*NREQ-1:0] i_req_n,
  output logic [NREQ-1:0]   o_done,
  output logic              o_err,
  output logic              o_busy,
  output logic              o_div_en,
  output logic [3:0]        o_div_n
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int LW = $clog2(LOCK + 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE - 1);
  localparam logic [LW-1:0] LOCK_INIT   = LW'(LOCK - 1);
  localparam logic [3:0]    DEF_RATIO   = 4'(DEF_N);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_LOAD  = 3'd2,
    S_LOCK  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_settle_cnt, w_settle_cnt_nxt;
  logic [LW-1:0]   r_lock_cnt, w_lock_cnt_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [IW-1:0]   r_win, w_win_nxt;
  logic [3:0]      r_lat_n, w_lat_n_nxt;
  logic            r_div_en, w_div_en_nxt;
  logic [3:0]      r_div_n, w_div_n_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  logic            r_busy, w_busy_nxt;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [3:0]      w_win_n;
  logic [IW-1:0]   w_ptr_inc;

  // Index of the k-th requester counted from base, wrapping at NREQ.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Round-robin winner: first set request at or after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && i_req[wrap_idx(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = wrap_idx(r_ptr, k);
      end
    end
  end

  // Ratio slice of the winner and the pointer value that follows it.
  always_comb begin
    w_win_n = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IW'(i)) w_win_n = i_req_n[4*i +: 4];
    end
    w_ptr_inc = (w_win == IW'(NREQ - 1)) ? '0 : w_win + IW'(1);
  end

  // Next-state and registered-output values for the sequencing FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_settle_cnt_nxt = r_settle_cnt;
    w_lock_cnt_nxt   = r_lock_cnt;
    w_ptr_nxt        = r_ptr;
    w_win_nxt        = r_win;
    w_lat_n_nxt      = r_lat_n;
    w_div_en_nxt     = r_div_en;
    w_div_n_nxt      = r_div_n;
    w_done_nxt       = '0;
    w_err_nxt        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_en_nxt = 1'b1;
        if (w_found) begin
          w_win_nxt   = w_win;
          w_lat_n_nxt = w_win_n;
          w_ptr_nxt   = w_ptr_inc;
          if (w_win_n < 4'd2) begin
            // Ratios 0 and 1 are not divisible; answer at once and leave the divider running.
            w_state_nxt       = S_DONE;
            w_done_nxt[w_win] = 1'b1;
            w_err_nxt         = 1'b1;
          end
`ifdef FREQDIV_CTRL_SKIP_EN
          else if (w_win_n == r_div_n) begin
            // Divider already runs at this ratio; no need to stop it.
            w_state_nxt       = S_DONE;
            w_done_nxt[w_win] = 1'b1;
          end
`endif
          else begin
            w_state_nxt      = S_DRAIN;
            w_div_en_nxt     = 1'b0;
            w_settle_cnt_nxt = SETTLE_INIT;
          end
        end
      end
      S_DRAIN: begin
        w_div_en_nxt = 1'b0;
        if (r_settle_cnt == '0) w_state_nxt = S_LOAD;
        else w_settle_cnt_nxt = r_settle_cnt - SW'(1);
      end
      S_LOAD: begin
        // Ratio is swapped while the divider is still held off; it restarts on the same edge.
        w_div_n_nxt    = r_lat_n;
        w_div_en_nxt   = 1'b1;
        w_lock_cnt_nxt = LOCK_INIT;
        w_state_nxt    = S_LOCK;
      end
      S_LOCK: begin
        if (r_lock_cnt == '0) begin
          w_state_nxt       = S_DONE;
          w_done_nxt[r_win] = 1'b1;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt - LW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clkin) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_lock_cnt   <= '0;
      r_ptr        <= '0;
      r_win        <= '0;
      r_lat_n      <= '0;
      r_div_en     <= 1'b0;
      r_div_n      <= DEF_RATIO;
      r_done       <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_ptr        <= w_ptr_nxt;
      r_win        <= w_win_nxt;
      r_lat_n      <= w_lat_n_nxt;
      r_div_en     <= w_div_en_nxt;
      r_div_n      <= w_div_n_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign o_done   = r_done;
  assign o_err    = r_err;
  assign o_busy   = r_busy;
  assign o_div_en = r_div_en;
  assign o_div_n  = r_div_n;

endmodule

// File: tb/tb_pes_freqdiv_ctrl.sv
// Directed bench for pes_freqdiv_ctrl with default parameters (NREQ=4, SETTLE=2, LOCK=16, DEF_N=2).
// Full-sequence latency is 20 cycles, rejected ratios answer in 1 cycle.
// Requesters drop req as soon as their done bit is observed.
module tb_pes_freqdiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_n;
  logic [3:0]  done;
  logic        err;
  logic        busy;
  logic        div_en;
  logic [3:0]  div_n;

  int checks   = 0;
  int failures = 0;

  int         lat, low, chg;
  logic [3:0] d;
  logic       e, enc;

  pes_freqdiv_ctrl #(
    .NREQ(4), .SETTLE(2), .LOCK(16), .DEF_N(2)
  ) dut (
    .i_clkin (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_req_n (req_n),
    .o_done  (done),
    .o_err   (err),
    .o_busy  (busy),
    .o_div_en(div_en),
    .o_div_n (div_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Steps the clock until done rises or max cycles pass. Cycle 1 is the cycle after the
  // first edge of the call. lat=-1 on timeout.
  task automatic wait_done(input int max, output int olat, output logic [3:0] od, output logic oe,
                           output int olow, output int ochg, output logic oenc);
    logic [3:0] n0;
    n0   = div_n;
    olat = -1; od = '0; oe = 1'b0; olow = 0; ochg = -1; oenc = 1'b0;
    for (int c = 1; c <= max; c++) begin
      tick();
      if (!div_en) olow++;
      if (ochg < 0 && div_n !== n0) begin
        ochg = c;
        oenc = div_en;
      end
      if (done !== 4'b0) begin
        olat = c;
        od   = done;
        oe   = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_n = '0;
    tick(); tick();
    checks++; if (div_en !== 1'b0) begin failures++; $display("FAIL rst_div_en got=%b exp=0", div_en); end
    checks++; if (div_n !== 4'd2) begin failures++; $display("FAIL rst_div_n got=%0d exp=2", div_n); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    tick();
    checks++; if (div_en !== 1'b1) begin failures++; $display("FAIL first_edge_div_en got=%b exp=1", div_en); end
    repeat (4) tick();
    checks++; if (div_en !== 1'b1 || div_n !== 4'd2) begin failures++; $display("FAIL idle_div got en=%b n=%0d exp en=1 n=2", div_en, div_n); end
    checks++; if (done !== 4'b0 || busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL idle_flags got done=%b busy=%b err=%b exp 0000/0/0", done, busy, err); end
  endtask

  task automatic test_single();
    req_n[7:4] = 4'd5;
    req = 4'b0010;
    wait_done(40, lat, d, e, low, chg, enc);
    req = 4'b0000;
    checks++; if (lat !== 20) begin failures++; $display("FAIL single_latency got=%0d exp=20", lat); end
    checks++; if (d !== 4'b0010 || e !== 1'b0) begin failures++; $display("FAIL single_done got done=%b err=%b exp 0010/0", d, e); end
    checks++; if (low !== 3) begin failures++; $display("FAIL single_en_low got=%0d exp=3", low); end
    checks++; if (chg !== 4 || enc !== 1'b1) begin failures++; $display("FAIL single_n_change got cyc=%0d en=%b exp cyc=4 en=1", chg, enc); end
    checks++; if (div_n !== 4'd5 || busy !== 1'b1) begin failures++; $display("FAIL single_state got n=%0d busy=%b exp n=5 busy=1", div_n, busy); end
    tick();
    checks++; if (done !== 4'b0) begin failures++; $display("FAIL single_done_width got=%b exp=0000", done); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_d [6];
    logic [3:0] exp_n [6];
    exp_d = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100};
    exp_n = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd6, 4'd8};
    do_reset();
    req_n = {4'd9, 4'd8, 4'd7, 4'd6};
    req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      if (g == 4) begin
        tick();
        req = 4'b0101;
      end
      wait_done(40, lat, d, e, low, chg, enc);
      req = req & ~d;
      checks++; if (d !== exp_d[g]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", g, d, exp_d[g]); end
      checks++; if (div_n !== exp_n[g]) begin failures++; $display("FAIL rr_ratio%0d got=%0d exp=%0d", g, div_n, exp_n[g]); end
    end
    req = '0;
  endtask

  task automatic test_reject();
    tick();
    req_n[15:12] = 4'd0;
    req = 4'b1000;
    wait_done(10, lat, d, e, low, chg, enc);
    req = '0;
    checks++; if (lat !== 1 || d !== 4'b1000 || e !== 1'b1) begin failures++; $display("FAIL reject0 got lat=%0d done=%b err=%b exp 1/1000/1", lat, d, e); end
    checks++; if (low !== 0 || div_n !== 4'd8) begin failures++; $display("FAIL reject0_div got low=%0d n=%0d exp 0/8", low, div_n); end
    tick();
    req_n[15:12] = 4'd1;
    req = 4'b1000;
    wait_done(10, lat, d, e, low, chg, enc);
    req = '0;
    checks++; if (lat !== 1 || d !== 4'b1000 || e !== 1'b1) begin failures++; $display("FAIL reject1 got lat=%0d done=%b err=%b exp 1/1000/1", lat, d, e); end
    checks++; if (low !== 0 || div_n !== 4'd8 || div_en !== 1'b1) begin failures++; $display("FAIL reject1_div got low=%0d n=%0d en=%b exp 0/8/1", low, div_n, div_en); end
    tick();
    checks++; if (done !== 4'b0 || err !== 1'b0) begin failures++; $display("FAIL reject_clear got done=%b err=%b exp 0000/0", done, err); end
  endtask

  task automatic test_reset_in_lock();
    tick();
    req_n[7:4] = 4'd11;
    req = 4'b0010;
    tick();
    repeat (10) tick();
    checks++; if (busy !== 1'b1 || div_n !== 4'd11 || div_en !== 1'b1) begin failures++; $display("FAIL lock_state got busy=%b n=%0d en=%b exp 1/11/1", busy, div_n, div_en); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (div_n !== 4'd2 || div_en !== 1'b0) begin failures++; $display("FAIL lock_rst_div got n=%0d en=%b exp 2/0", div_n, div_en); end
    checks++; if (busy !== 1'b0 || done !== 4'b0) begin failures++; $display("FAIL lock_rst_flags got busy=%b done=%b exp 0/0000", busy, done); end
    wait_done(40, lat, d, e, low, chg, enc);
    req = '0;
    checks++; if (lat !== 20 || d !== 4'b0010) begin failures++; $display("FAIL lock_reserve got lat=%0d done=%b exp 20/0010", lat, d); end
    checks++; if (div_n !== 4'd11) begin failures++; $display("FAIL lock_reserve_n got=%0d exp=11", div_n); end
  endtask

  task automatic test_same_ratio();
    tick();
    tick();
    req_n[3:0] = 4'd11;
    req = 4'b0001;
    wait_done(40, lat, d, e, low, chg, enc);
    req = '0;
`ifdef FREQDIV_CTRL_SKIP_EN
    checks++; if (lat !== 1 || low !== 0) begin failures++; $display("FAIL same_skip got lat=%0d low=%0d exp 1/0", lat, low); end
`else
    checks++; if (lat !== 20 || low !== 3) begin failures++; $display("FAIL same_full got lat=%0d low=%0d exp 20/3", lat, low); end
`endif
    checks++; if (d !== 4'b0001 || e !== 1'b0 || div_n !== 4'd11) begin failures++; $display("FAIL same_done got done=%b err=%b n=%0d exp 0001/0/11", d, e, div_n); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reject();
    test_reset_in_lock();
    test_same_ratio();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
